// File: rtl/kws_wb_ctrl.sv
// Wishbone control/observation slave for the KWS pipeline: sequencer start/opcode, per-tap FIFOs,
// sticky status, overflow tracking and interrupt. Define KWS_WB_CTRL_TS_EN to add the done timestamp.
module kws_wb_ctrl #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NCH   = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NCH-1:0]    ch_valid_i,
    input  logic [NCH*DW-1:0] ch_data_i,
    input  logic [NCH*AW-1:0] ch_addr_i,
    input  logic              done_i,
    output logic              start_o,
    output logic [3:0]        opcode_o,
    output logic              irq_o
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_OPCODE = 6'h01;
    localparam logic [5:0] A_IRQ_EN = 6'h02;
    localparam logic [5:0] A_STATUS = 6'h03;
    localparam logic [5:0] A_CH_SEL = 6'h04;
    localparam logic [5:0] A_LEVEL  = 6'h05;
    localparam logic [5:0] A_DATA   = 6'h06;
    localparam logic [5:0] A_ADDR   = 6'h07;
    localparam logic [5:0] A_OVF    = 6'h08;
    localparam logic [5:0] A_TSTAMP = 6'h09;

    logic                   r_ack;
    logic [31:0]            r_dat;
    logic                   r_start;
    logic [3:0]             r_opcode;
    logic [1:0]             r_irq_en;
    logic                   r_busy;
    logic                   r_done_st;
    logic                   r_ovf_st;
    logic [3:0]             r_ch_sel;
    logic [NCH-1:0]         r_ovf;

    logic                   w_accept;
    logic                   w_wr;
    logic                   w_rd;
    logic [5:0]             w_off;
    logic                   w_flush;
    logic                   w_start_go;
    logic                   w_pop_req;
    logic [NCH-1:0]         w_ovf_set;
    logic [NCH-1:0]         w_ovf_clr;
    logic [NCH-1:0][LW-1:0] w_level;
    logic [NCH-1:0][DW-1:0] w_head_data;
    logic [NCH-1:0][AW-1:0] w_head_addr;
    logic [LW-1:0]          w_sel_level;
    logic [DW-1:0]          w_sel_data;
    logic [AW-1:0]          w_sel_addr;
    logic [31:0]            w_tstamp;
    logic [31:0]            w_rdata;
    logic                   w_unused;

    // A new transfer is only taken while no ack is pending, so held strobes ack on alternate cycles.
    assign w_accept   = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_wr       = w_accept & wbs_we_i & wbs_sel_i[0];
    assign w_rd       = w_accept & ~wbs_we_i;
    assign w_off      = wbs_adr_i[7:2];
    assign w_flush    = w_wr & (w_off == A_CTRL) & wbs_dat_i[1];
    assign w_start_go = w_wr & (w_off == A_CTRL) & wbs_dat_i[0] & ~r_busy;
    assign w_pop_req  = w_rd & (w_off == A_DATA);
    assign w_ovf_clr  = (w_wr && w_off == A_OVF) ? wbs_dat_i[NCH-1:0] : '0;

    assign w_unused = &{1'b0, wbs_adr_i, wbs_dat_i, wbs_sel_i};

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [LW-1:0] r_level;
        logic [PW-1:0] r_wptr;
        logic [PW-1:0] r_rptr;
        logic [DW-1:0] r_mem_data [DEPTH];
        logic [AW-1:0] r_mem_addr [DEPTH];
        logic          w_empty;
        logic          w_full;
        logic          w_pop;
        logic          w_push;

        assign w_empty = (r_level == '0);
        assign w_full  = (r_level == LW'(DEPTH));
        assign w_pop   = w_pop_req & (r_ch_sel == 4'(k)) & ~w_empty;
        // A same-cycle pop frees the slot, so a push into a full FIFO is then accepted.
        assign w_push       = ch_valid_i[k] & ~w_flush & (~w_full | w_pop);
        assign w_ovf_set[k] = ch_valid_i[k] & ~w_flush & w_full & ~w_pop;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_level <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else if (w_flush) begin
                r_level <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
                if (w_push && !w_pop)      r_level <= r_level + LW'(1);
                else if (w_pop && !w_push) r_level <= r_level - LW'(1);
            end
        end

        // NOTE: storage has no reset; r_level alone says which entries are valid, and empty reads return 0.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem_data[r_wptr] <= ch_data_i[k*DW +: DW];
                r_mem_addr[r_wptr] <= ch_addr_i[k*AW +: AW];
            end
        end

        assign w_level[k]     = r_level;
        assign w_head_data[k] = r_mem_data[r_rptr];
        assign w_head_addr[k] = r_mem_addr[r_rptr];
    end

`ifdef KWS_WB_CTRL_TS_EN
    logic [31:0] r_cycle;
    logic [31:0] r_tstamp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle  <= '0;
            r_tstamp <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (done_i) r_tstamp <= r_cycle;
        end
    end

    assign w_tstamp = r_tstamp;
`else
    assign w_tstamp = '0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_sel_level = '0;
        w_sel_data  = '0;
        w_sel_addr  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_ch_sel == 4'(k)) begin
                w_sel_level = w_level[k];
                w_sel_data  = w_head_data[k];
                w_sel_addr  = w_head_addr[k];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            A_OPCODE: w_rdata = {28'd0, r_opcode};
            A_IRQ_EN: w_rdata = {30'd0, r_irq_en};
            A_STATUS: w_rdata = {29'd0, r_ovf_st, r_done_st, r_busy};
            A_CH_SEL: w_rdata = {28'd0, r_ch_sel};
            A_LEVEL:  w_rdata = 32'(w_sel_level);
            A_DATA:   w_rdata = (w_sel_level != '0) ? 32'(w_sel_data) : 32'd0;
            A_ADDR:   w_rdata = (w_sel_level != '0) ? 32'(w_sel_addr) : 32'd0;
            A_OVF:    w_rdata = 32'(r_ovf);
            A_TSTAMP: w_rdata = w_tstamp;
            default:  w_rdata = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_accept;
            if (w_rd) r_dat <= w_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start   <= 1'b0;
            r_opcode  <= '0;
            r_irq_en  <= '0;
            r_busy    <= 1'b0;
            r_done_st <= 1'b0;
            r_ovf_st  <= 1'b0;
            r_ch_sel  <= '0;
            r_ovf     <= '0;
        end else begin
            r_start <= w_start_go;
            if (w_wr) begin
                case (w_off)
                    A_OPCODE: r_opcode <= wbs_dat_i[3:0];
                    A_IRQ_EN: r_irq_en <= wbs_dat_i[1:0];
                    A_CH_SEL: if (32'(wbs_dat_i[3:0]) < NCH) r_ch_sel <= wbs_dat_i[3:0];
                    default: ;
                endcase
            end
            // A start is only taken while idle, so done always wins against a start while busy.
            if (w_start_go)  r_busy <= 1'b1;
            else if (done_i) r_busy <= 1'b0;

            if (done_i)
                r_done_st <= 1'b1;
            else if (w_wr && w_off == A_STATUS && wbs_dat_i[1])
                r_done_st <= 1'b0;

            if (|w_ovf_set)
                r_ovf_st <= 1'b1;
            else if (w_wr && w_off == A_STATUS && wbs_dat_i[2])
                r_ovf_st <= 1'b0;

            r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign start_o   = r_start;
    assign opcode_o  = r_opcode;
    assign irq_o     = (r_irq_en[0] & r_done_st) | (r_irq_en[1] & r_ovf_st);

endmodule

// File: tb/tb_kws_wb_ctrl.sv
// Directed self-checking bench for kws_wb_ctrl (default parameters). TSTAMP expectation follows
// KWS_WB_CTRL_TS_EN: done sampled on the 101st rising edge after reset release captures 100.
module tb_kws_wb_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NCH   = 8;
    localparam int DEPTH = 4;

`ifdef KWS_WB_CTRL_TS_EN
    localparam logic [31:0] TS_EXP = 32'd100;
`else
    localparam logic [31:0] TS_EXP = 32'd0;
`endif

    logic              clk;
    logic              rst_n;
    logic              wbs_stb_i;
    logic              wbs_cyc_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic [NCH-1:0]    ch_valid_i;
    logic [NCH*DW-1:0] ch_data_i;
    logic [NCH*AW-1:0] ch_addr_i;
    logic              done_i;
    logic              start_o;
    logic [3:0]        opcode_o;
    logic              irq_o;

    int   checks;
    int   errors;
    logic last_start;

    kws_wb_ctrl #(.DW(DW), .AW(AW), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .ch_valid_i (ch_valid_i),
        .ch_data_i  (ch_data_i),
        .ch_addr_i  (ch_addr_i),
        .done_i     (done_i),
        .start_o    (start_o),
        .opcode_o   (opcode_o),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n      = 1'b0;
        wbs_stb_i  = 1'b0;
        wbs_cyc_i  = 1'b0;
        wbs_we_i   = 1'b0;
        wbs_sel_i  = 4'h0;
        wbs_adr_i  = '0;
        wbs_dat_i  = '0;
        ch_valid_i = '0;
        ch_data_i  = '0;
        ch_addr_i  = '0;
        done_i     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One bus transfer; pmask optionally pushes a sample on the accepting edge.
    task automatic wb_xfer(input logic we, input logic [5:0] off, input logic [31:0] wdat,
                           input logic [3:0] sel, input logic [NCH-1:0] pmask,
                           input logic [DW-1:0] pdata, input logic [AW-1:0] paddr,
                           output logic [31:0] rdat);
        int n;
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;
        wbs_we_i   = we;
        wbs_sel_i  = sel;
        wbs_adr_i  = {24'd0, off, 2'b00};
        wbs_dat_i  = wdat;
        ch_valid_i = pmask;
        for (int k = 0; k < NCH; k++) begin
            if (pmask[k]) begin
                ch_data_i[k*DW +: DW] = pdata;
                ch_addr_i[k*AW +: AW] = paddr;
            end
        end
        @(posedge clk);
        #1;
        ch_valid_i = '0;
        n = 0;
        while (!wbs_ack_o && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (wbs_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout off=%0h got ack %b expected 1", off, wbs_ack_o);
        end
        rdat       = wbs_dat_o;
        last_start = start_o;
        wbs_cyc_i  = 1'b0;
        wbs_stb_i  = 1'b0;
        wbs_we_i   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [5:0] off, input logic [31:0] wdat, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_xfer(1'b1, off, wdat, sel, '0, '0, '0, dummy);
    endtask

    task automatic wb_read(input logic [5:0] off, output logic [31:0] rdat);
        wb_xfer(1'b0, off, 32'd0, 4'hF, '0, '0, '0, rdat);
    endtask

    task automatic push(input int ch, input logic [DW-1:0] d, input logic [AW-1:0] a);
        ch_valid_i[ch]        = 1'b1;
        ch_data_i[ch*DW +: DW] = d;
        ch_addr_i[ch*AW +: AW] = a;
        @(posedge clk);
        #1;
        ch_valid_i = '0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        do_reset();
        checks++;
        if ({wbs_ack_o, start_o, irq_o, opcode_o} !== 7'd0 || wbs_dat_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b start=%b irq=%b op=%0h dat=%0h expected all 0",
                     wbs_ack_o, start_o, irq_o, opcode_o, wbs_dat_o);
        end
        for (int i = 0; i < 10; i++) begin
            wb_read(6'(i), r);
            checks++;
            if (r !== 32'd0) begin
                errors++;
                $display("FAIL reset_read off=%0h got %0h expected 0", i, r);
            end
        end
    endtask

    task automatic test_start();
        logic [31:0] r;
        wb_write(6'h01, 32'h5, 4'hF);
        checks++;
        if (opcode_o !== 4'h5) begin errors++; $display("FAIL opcode_out got %0h expected 5", opcode_o); end
        wb_write(6'h01, 32'hA, 4'hE);
        wb_read(6'h01, r);
        checks++;
        if (r !== 32'h5) begin errors++; $display("FAIL sel0_gate got %0h expected 5", r); end
        wb_write(6'h00, 32'h1, 4'hF);
        checks++;
        if (last_start !== 1'b1) begin errors++; $display("FAIL start_pulse got %b expected 1", last_start); end
        checks++;
        if (start_o !== 1'b0) begin errors++; $display("FAIL start_one_cycle got %b expected 0", start_o); end
        wb_read(6'h03, r);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL status_busy got %0h expected 1", r); end
        wb_write(6'h00, 32'h1, 4'hF);
        checks++;
        if (last_start !== 1'b0) begin errors++; $display("FAIL start_while_busy got %b expected 0", last_start); end
        done_i = 1'b1;
        @(posedge clk);
        #1;
        done_i = 1'b0;
        wb_read(6'h03, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL status_done got %0h expected 2", r); end
        wb_write(6'h02, 32'h1, 4'hF);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_done got %b expected 1", irq_o); end
        wb_write(6'h03, 32'h2, 4'hF);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_done_clr got %b expected 0", irq_o); end
        wb_read(6'h03, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL status_w1c got %0h expected 0", r); end
        wb_write(6'h02, 32'h0, 4'hF);
    endtask

    task automatic test_fifo();
        logic [31:0] r;
        logic [31:0] exp_seq [8];
        logic [5:0]  off_seq [8];
        push(2, 32'h11, 5'd1);
        push(2, 32'h22, 5'd2);
        push(2, 32'h33, 5'd3);
        wb_write(6'h04, 32'h2, 4'hF);
        off_seq = '{6'h05, 6'h07, 6'h06, 6'h07, 6'h05, 6'h06, 6'h06, 6'h06};
        exp_seq = '{32'd3, 32'd1, 32'h11, 32'd2, 32'd2, 32'h22, 32'h33, 32'd0};
        for (int i = 0; i < 8; i++) begin
            wb_read(off_seq[i], r);
            checks++;
            if (r !== exp_seq[i]) begin
                errors++;
                $display("FAIL fifo_step%0d off=%0h got %0h expected %0h", i, off_seq[i], r, exp_seq[i]);
            end
        end
        wb_write(6'h04, 32'h8, 4'hF);
        wb_read(6'h04, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL ch_sel_range got %0h expected 2", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        for (int i = 0; i <= DEPTH; i++) push(0, 32'hA0 + 32'(i), 5'(i + 1));
        wb_write(6'h04, 32'h0, 4'hF);
        wb_read(6'h05, r);
        checks++;
        if (r !== 32'(DEPTH)) begin errors++; $display("FAIL ovf_level got %0h expected %0h", r, DEPTH); end
        wb_read(6'h08, r);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL ovf_bits got %0h expected 1", r); end
        wb_read(6'h03, r);
        checks++;
        if (r !== 32'h4) begin errors++; $display("FAIL ovf_sticky got %0h expected 4", r); end
        wb_write(6'h02, 32'h2, 4'hF);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_ovf got %b expected 1", irq_o); end
        wb_write(6'h08, 32'h1, 4'hF);
        wb_read(6'h08, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL ovf_w1c got %0h expected 0", r); end
        wb_write(6'h03, 32'h4, 4'hF);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_ovf_clr got %b expected 0", irq_o); end
    endtask

    task automatic test_pop_push_flush();
        logic [31:0] r;
        wb_xfer(1'b0, 6'h06, 32'd0, 4'hF, 8'h01, 32'hB5, 5'd9, r);
        checks++;
        if (r !== 32'hA0) begin errors++; $display("FAIL full_pop_data got %0h expected a0", r); end
        wb_read(6'h05, r);
        checks++;
        if (r !== 32'(DEPTH)) begin errors++; $display("FAIL full_pop_level got %0h expected %0h", r, DEPTH); end
        wb_read(6'h03, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL full_pop_no_ovf got %0h expected 0", r); end
        wb_xfer(1'b1, 6'h00, 32'h2, 4'hF, 8'h01, 32'hBB, 5'd4, r);
        wb_read(6'h05, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL flush_level got %0h expected 0", r); end
        wb_read(6'h08, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL flush_no_ovf got %0h expected 0", r); end
        wb_xfer(1'b0, 6'h06, 32'd0, 4'hF, 8'h01, 32'hC5, 5'd7, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL empty_pop got %0h expected 0", r); end
        wb_read(6'h07, r);
        checks++;
        if (r !== 32'h7) begin errors++; $display("FAIL empty_push_addr got %0h expected 7", r); end
        wb_read(6'h06, r);
        checks++;
        if (r !== 32'hC5) begin errors++; $display("FAIL empty_push_data got %0h expected c5", r); end
        wb_write(6'h20, 32'hFF, 4'hF);
        wb_read(6'h20, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL unmapped got %0h expected 0", r); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] acks;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = {24'd0, 6'h01, 2'b00};
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk);
            #1;
            acks[i] = wbs_ack_o;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        checks++;
        if (acks !== 4'b1010 || wbs_dat_o !== 32'h5) begin
            errors++;
            $display("FAIL back_to_back got acks=%b dat=%0h expected 1010 dat=5", acks, wbs_dat_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_tstamp();
        logic [31:0] r;
        do_reset();
        repeat (100) @(posedge clk);
        #1;
        done_i = 1'b1;
        @(posedge clk);
        #1;
        done_i = 1'b0;
        wb_read(6'h09, r);
        checks++;
        if (r !== TS_EXP) begin errors++; $display("FAIL tstamp got %0d expected %0d", r, TS_EXP); end
        wb_read(6'h01, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL opcode_after_reset got %0h expected 0", r); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        last_start = 1'b0;
        test_reset();
        test_start();
        test_fifo();
        test_overflow();
        test_pop_push_flush();
        test_back_to_back();
        test_tstamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
